// File: rtl/ise_ctrl.sv
// ise_ctrl: sequencer for the image-sort engine.
// Receives PIX pixels per image, runs classification for each of IMAGE_NUM
// images, starts the sort, then reads the sorted results back one slot per cycle.
// Handshake: in_valid qualifies a pixel; while busy is high the source holds its
// pixel and any in_valid is ignored (no accumulate, no count). cls_done and
// sort_done are single-cycle completion pulses that are honoured only in their
// own state and only after the matching start pulse.
module ise_ctrl #(
   parameter int IMAGE_NUM  = 32,
   parameter int IMAGE_SIZE = 128
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [4:0] image_in_index,
   output logic       busy,
   output logic       acc_en,
   output logic       acc_clr,
   output logic [4:0] cur_index,
   output logic       cls_start,
   input  logic       cls_done,
   output logic       sort_start,
   input  logic       sort_done,
   output logic       rd_en,
   output logic [4:0] rd_addr,
   output logic       out_valid,
   output logic       err,
   output logic [2:0] state_dbg
);

   localparam int PIX   = IMAGE_SIZE * IMAGE_SIZE;
   localparam int PIX_W = (PIX > 1) ? $clog2(PIX) : 1;
   localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(PIX - 1);
   localparam logic [5:0]       IMG_LAST  = 6'(IMAGE_NUM - 1);
   localparam logic [4:0]       ADDR_LAST = 5'(IMAGE_NUM - 1);

   typedef enum logic [2:0] {
      S_RECV  = 3'd0,
      S_CLASS = 3'd1,
      S_SORT  = 3'd2,
      S_OUT   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t           state, state_nxt;
   logic [PIX_W-1:0] pix_cnt;
   logic [5:0]       img_cnt;
   logic [4:0]       out_cnt;
   logic             pix_acc;
   logic             pix_last;
   logic             cls_ack;
   logic             sort_ack;
   logic             idx_bad;
   logic             clr_pulse;

   assign state_dbg = state;
   assign acc_en    = pix_acc;
   assign acc_clr   = clr_pulse;
   assign rd_en     = (state == S_OUT);
   assign rd_addr   = out_cnt;

   // Next-state and strobe decode; reset gates the pixel strobe so every output is low in reset.
   always_comb begin
      state_nxt = state;
      clr_pulse = 1'b0;
      pix_acc   = reset & in_valid & (state == S_RECV);
      pix_last  = pix_acc & (pix_cnt == PIX_LAST);
      cls_ack   = (state == S_CLASS) & cls_done & ~cls_start;
      sort_ack  = (state == S_SORT) & sort_done & ~sort_start;
      idx_bad   = pix_acc & (pix_cnt != '0) & (image_in_index != cur_index);
      case (state)
         S_RECV: begin
            if (pix_last) state_nxt = S_CLASS;
         end
         S_CLASS: begin
            if (cls_ack) begin
               if (img_cnt == IMG_LAST) begin
                  state_nxt = S_SORT;
               end else begin
                  state_nxt = S_RECV;
                  clr_pulse = 1'b1;
               end
            end
         end
         S_SORT: begin
            if (sort_ack) state_nxt = S_OUT;
         end
         S_OUT: begin
            if (out_cnt == ADDR_LAST) state_nxt = S_DONE;
         end
         S_DONE: begin
            state_nxt = S_DONE;
         end
         default: begin
            state_nxt = S_RECV;
         end
      endcase
   end

   // State register plus registered busy and entry pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_RECV;
         busy       <= 1'b0;
         cls_start  <= 1'b0;
         sort_start <= 1'b0;
         out_valid  <= 1'b0;
      end else begin
         state      <= state_nxt;
         busy       <= (state_nxt != S_RECV);
         cls_start  <= (state_nxt == S_CLASS) && (state != S_CLASS);
         sort_start <= (state_nxt == S_SORT) && (state != S_SORT);
         out_valid  <= rd_en;
      end
   end

   // Pixel counter and image index capture on the first pixel of each image.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pix_cnt   <= '0;
         cur_index <= '0;
      end else if (pix_acc) begin
         pix_cnt <= pix_last ? '0 : pix_cnt + 1'b1;
         if (pix_cnt == '0) cur_index <= image_in_index;
      end
   end

   // Image counter advances on each accepted classification result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         img_cnt <= '0;
      end else if (cls_ack) begin
         img_cnt <= img_cnt + 1'b1;
      end
   end

   // Readout address walks 0..IMAGE_NUM-1 while in OUT, then parks at 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_cnt <= '0;
      end else if (state == S_OUT) begin
         out_cnt <= (out_cnt == ADDR_LAST) ? '0 : out_cnt + 1'b1;
      end
   end

   // Sticky protocol error: index change mid-image or a stray completion pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err <= 1'b0;
      end else if (idx_bad || (cls_done && state != S_CLASS) ||
                   (sort_done && state != S_SORT)) begin
         err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ise_ctrl.sv
// tb_ise_ctrl: directed bench for ise_ctrl with IMAGE_SIZE = 4, IMAGE_NUM = 4.
module tb_ise_ctrl;

  localparam int IMAGE_NUM  = 4;
  localparam int IMAGE_SIZE = 4;
  localparam int PIX        = IMAGE_SIZE * IMAGE_SIZE;

  localparam int ST_RECV  = 0;
  localparam int ST_CLASS = 1;
  localparam int ST_SORT  = 2;
  localparam int ST_OUT   = 3;
  localparam int ST_DONE  = 4;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [4:0] image_in_index;
  logic       busy;
  logic       acc_en;
  logic       acc_clr;
  logic [4:0] cur_index;
  logic       cls_start;
  logic       cls_done;
  logic       sort_start;
  logic       sort_done;
  logic       rd_en;
  logic [4:0] rd_addr;
  logic       out_valid;
  logic       err;
  logic [2:0] state_dbg;

  int checks;
  int errors;
  int exp_err;
  int acc_cnt;
  int ov_cnt;

  ise_ctrl #(.IMAGE_NUM(IMAGE_NUM), .IMAGE_SIZE(IMAGE_SIZE)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .image_in_index (image_in_index),
    .busy           (busy),
    .acc_en         (acc_en),
    .acc_clr        (acc_clr),
    .cur_index      (cur_index),
    .cls_start      (cls_start),
    .cls_done       (cls_done),
    .sort_start     (sort_start),
    .sort_done      (sort_done),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .out_valid      (out_valid),
    .err            (err),
    .state_dbg      (state_dbg)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: bench did not complete within time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_acc_en"}, acc_en, 0);
    check({tag, "_acc_clr"}, acc_clr, 0);
    check({tag, "_cur_index"}, cur_index, 0);
    check({tag, "_cls_start"}, cls_start, 0);
    check({tag, "_sort_start"}, sort_start, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_state"}, state_dbg, ST_RECV);
  endtask

  // Feed one image; pixels from chg_at onward carry new_idx instead of idx.
  task automatic feed_image(input int idx, input int chg_at, input int new_idx);
    acc_cnt = 0;
    for (int p = 0; p < PIX; p++) begin
      @(negedge clk);
      in_valid       = 1'b1;
      image_in_index = 5'((p >= chg_at) ? new_idx : idx);
      #1;
      check("pix_acc_en", acc_en, 1);
      check("pix_busy", busy, 0);
      check("pix_err", err, exp_err);
      if (p == 1) check("pix_cur_index", cur_index, idx);
      if (acc_en) acc_cnt++;
      if (p > 0 && p >= chg_at && new_idx != idx) exp_err = 1;
    end
    // first CLASS cycle, in_valid still held high
    @(negedge clk);
    #1;
    check("img_acc_count", acc_cnt, PIX);
    check("cls_entry_busy", busy, 1);
    check("cls_entry_start", cls_start, 1);
    check("cls_entry_acc_en", acc_en, 0);
    check("cls_entry_state", state_dbg, ST_CLASS);
    check("cls_entry_cur_index", cur_index, idx);
    check("cls_entry_err", err, exp_err);
  endtask

  // Called in the cls_start cycle; returns cls_done after delay cycles.
  task automatic do_class(input bit last, input bit early, input int delay);
    cls_done = early;
    #1;
    check("cls_c0_acc_clr", acc_clr, 0);
    for (int c = 1; c < delay; c++) begin
      @(negedge clk);
      cls_done = 1'b0;
      #1;
      check("cls_wait_state", state_dbg, ST_CLASS);
      check("cls_wait_start", cls_start, 0);
      check("cls_wait_acc_en", acc_en, 0);
      check("cls_wait_busy", busy, 1);
    end
    @(negedge clk);
    cls_done = 1'b1;
    #1;
    check("cls_done_acc_clr", acc_clr, last ? 0 : 1);
    check("cls_done_acc_en", acc_en, 0);
    @(negedge clk);
    cls_done = 1'b0;
    in_valid = 1'b0;
    #1;
    check("cls_after_busy", busy, last ? 1 : 0);
    check("cls_after_state", state_dbg, last ? ST_SORT : ST_RECV);
    check("cls_after_sort_start", sort_start, last ? 1 : 0);
    check("cls_after_acc_clr", acc_clr, 0);
  endtask

  // Called in the sort_start cycle; sort_done in that cycle must be ignored.
  // stop_at < 0 runs readout to DONE, otherwise reset is asserted at that rd_addr.
  task automatic do_sort_out(input int stop_at);
    sort_done = 1'b1;
    @(negedge clk);
    sort_done = 1'b0;
    #1;
    check("sort_early_state", state_dbg, ST_SORT);
    check("sort_early_start", sort_start, 0);
    check("sort_early_err", err, exp_err);
    repeat (3) @(negedge clk);
    sort_done = 1'b1;
    @(negedge clk);
    sort_done = 1'b0;
    ov_cnt = 0;
    for (int k = 0; k < IMAGE_NUM; k++) begin
      #1;
      check("out_rd_en", rd_en, 1);
      check("out_rd_addr", rd_addr, k);
      check("out_valid_lag", out_valid, (k > 0) ? 1 : 0);
      check("out_busy", busy, 1);
      if (out_valid) ov_cnt++;
      if (k == stop_at) return;
      @(negedge clk);
    end
    #1;
    check("done_state", state_dbg, ST_DONE);
    check("done_rd_en", rd_en, 0);
    check("done_out_valid_last", out_valid, 1);
    if (out_valid) ov_cnt++;
    check("out_valid_count", ov_cnt, IMAGE_NUM);
    repeat (3) begin
      @(negedge clk);
      #1;
      check("done_busy", busy, 1);
      check("done_out_valid", out_valid, 0);
      check("done_pulses", {acc_en, acc_clr, cls_start, sort_start, rd_en}, 0);
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    exp_err        = 0;
    reset          = 1'b0;
    in_valid       = 1'b1;
    image_in_index = 5'd7;
    cls_done       = 1'b0;
    sort_done      = 1'b0;

    // reset state, with in_valid asserted to show it is masked
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");

    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;

    // run 1: full frame set, image 2 switches index at pixel 7
    feed_image(0, PIX, 0);
    do_class(1'b0, 1'b0, 3);
    feed_image(1, PIX, 1);
    do_class(1'b0, 1'b1, 3);
    feed_image(2, 7, 3);
    do_class(1'b0, 1'b0, 2);
    feed_image(3, PIX, 3);
    do_class(1'b1, 1'b0, 4);
    do_sort_out(-1);
    check("run1_err_sticky", err, 1);

    // reset out of DONE
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all_zero("reset_done");
    exp_err = 0;
    @(negedge clk);
    reset = 1'b1;

    // stray cls_done in RECV sets err without starting anything
    @(negedge clk);
    cls_done = 1'b1;
    @(negedge clk);
    cls_done = 1'b0;
    #1;
    check("stray_cls_err", err, 1);
    check("stray_cls_state", state_dbg, ST_RECV);
    check("stray_cls_start", cls_start, 0);
    exp_err = 1;

    // run 2: abort with reset at rd_addr 2
    feed_image(5, PIX, 5);
    do_class(1'b0, 1'b0, 3);
    feed_image(6, PIX, 6);
    do_class(1'b0, 1'b0, 3);
    feed_image(7, PIX, 7);
    do_class(1'b0, 1'b0, 3);
    feed_image(8, PIX, 8);
    do_class(1'b1, 1'b0, 3);
    do_sort_out(2);
    reset = 1'b0;
    #1;
    check_all_zero("reset_in_out");
    @(negedge clk);
    reset = 1'b1;
    ov_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (out_valid) ov_cnt++;
      check("post_abort_busy", busy, 0);
      check("post_abort_pulses", {acc_clr, cls_start, sort_start, rd_en}, 0);
    end
    check("post_abort_out_valid", ov_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
